// File: rtl/switch_egress_reasm.sv
// Per-port egress: buffers 128-bit switch cells, raises registered backpressure,
// and re-serialises each frame as a byte stream with sop/eop/valid/ready framing.
module switch_egress_reasm #(
  parameter int unsigned AW        = 6,
  parameter int unsigned BP_MARGIN = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cell_wr,
  input  logic [127:0] cell_din,
  input  logic         cell_first,
  input  logic         cell_last,
  output logic         cell_bp,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  input  logic         tx_ready,
  output logic         ovf_err,
  output logic         len_err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;

  // {sof, eof, word}
  logic [129:0]  mem [DEPTH];
  logic [AW:0]   wptr, rptr, used;
  logic [AW+1:0] free_w;
  logic [1:0]    beat;
  logic          full, empty, wr_ok;
  logic [129:0]  head;
  logic          head_sof, head_eof;

  state_t        state, state_n;
  logic [127:0]  cur_word;
  logic          cur_vld, cur_eof;
  logic [3:0]    cur_idx;
  logic [10:0]   bcnt;
  logic          first;
  logic [7:0]    cur_byte;

  logic          pop, ld, ld_eop, hdr_ld, len_set, need;
  logic          slot_free, last_in_word, eop_cnt;

  assign used     = wptr - rptr;
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign free_w   = (AW+2)'(DEPTH) - (AW+2)'(used);
  assign wr_ok    = cell_wr && !full;
  assign head     = mem[rptr[AW-1:0]];
  assign head_sof = head[129];
  assign head_eof = head[128];
  assign cur_byte = cur_word[{~cur_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr[AW-1:0]] <= {cell_first && (beat == 2'd0), cell_last && (beat == 2'd3), cell_din};
  end

  // Beat counter keeps advancing on dropped words so cell alignment survives overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      beat    <= '0;
      cell_bp <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (cell_wr)        beat    <= beat + 2'd1;
      if (wr_ok)          wptr    <= wptr + (AW+1)'(1);
      if (cell_wr && full) ovf_err <= 1'b1;
      cell_bp <= (free_w < (AW+2)'(BP_MARGIN));
    end
  end

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    ld           = 1'b0;
    ld_eop       = 1'b0;
    hdr_ld       = 1'b0;
    len_set      = 1'b0;
    need         = 1'b0;
    slot_free    = !tx_valid || tx_ready;
    last_in_word = (cur_idx == 4'hF);
    eop_cnt      = (bcnt == 11'd1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_sof) begin
            hdr_ld  = 1'b1;
            state_n = (head[10:0] == 11'd0) ? DRAIN : DATA;
          end
        end
      end
      DATA: begin
        ld   = cur_vld && slot_free;
        // Prefetch the next word in the same cycle the current one is exhausted.
        need = !cur_vld || (ld && last_in_word && !eop_cnt && !cur_eof);
        if (ld && eop_cnt) begin
          ld_eop  = 1'b1;
          state_n = cur_eof ? IDLE : DRAIN;
        end else if (ld && cur_eof && last_in_word) begin
          ld_eop  = 1'b1;
          len_set = 1'b1;
          state_n = IDLE;
        end else if (need && !empty) begin
          if (head_sof) begin
            ld_eop  = ld;
            len_set = 1'b1;
            state_n = IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!empty) begin
          if (head_sof) begin
            state_n = IDLE;
          end else begin
            pop = 1'b1;
            if (head_eof) state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rptr     <= '0;
      cur_word <= '0;
      cur_vld  <= 1'b0;
      cur_eof  <= 1'b0;
      cur_idx  <= '0;
      bcnt     <= '0;
      first    <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (len_set) len_err <= 1'b1;

      if (hdr_ld) begin
        bcnt  <= head[10:0];
        first <= 1'b1;
      end else if (ld) begin
        bcnt  <= bcnt - 11'd1;
        first <= 1'b0;
      end

      if (pop && state == DATA) begin
        cur_word <= head[127:0];
        cur_eof  <= head_eof;
        cur_idx  <= '0;
        cur_vld  <= 1'b1;
      end else if (ld) begin
        cur_idx <= cur_idx + 4'd1;
        if (last_in_word || ld_eop) cur_vld <= 1'b0;
      end

      if (ld) begin
        tx_data  <= cur_byte;
        tx_valid <= 1'b1;
        tx_sop   <= first;
        tx_eop   <= ld_eop;
      end else if (tx_ready) begin
        tx_data  <= '0;
        tx_valid <= 1'b0;
        tx_sop   <= 1'b0;
        tx_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_egress_reasm.sv
// Scoreboard bench for switch_egress_reasm: frames are modelled as byte lists,
// pushed on issue, and popped by an independent monitor on each accepted byte.
module tb_switch_egress_reasm;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cell_wr = 1'b0;
  logic [127:0] cell_din = '0;
  logic         cell_first = 1'b0;
  logic         cell_last = 1'b0;
  logic         tx_ready = 1'b0;
  logic         cell_bp;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_sop, tx_eop;
  logic         ovf_err, len_err;

  always #5 clk = ~clk;

  switch_egress_reasm #(.AW(6), .BP_MARGIN(8)) dut (
    .clk(clk), .rstn(rstn), .cell_wr(cell_wr), .cell_din(cell_din),
    .cell_first(cell_first), .cell_last(cell_last), .cell_bp(cell_bp),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_ready(tx_ready), .ovf_err(ovf_err), .len_err(len_err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rx_cnt = 0;
  int   ready_mode = 1;
  bit   exp_len_err = 1'b0;
  bit   nogap = 1'b0;
  bit   in_frame = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tx_ready patterns: 0 stalled, 1 always, 2 toggling, 3 random (75%)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        2:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    bit   hv = 1'b0;
    exp_t hval, e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hv = 1'b0;
        in_frame = 1'b0;
        continue;
      end
      if (hv)
        chk("hold_stable", {tx_valid, tx_data, tx_sop, tx_eop}, {1'b1, hval.d, hval.sop, hval.eop});
      if (nogap && in_frame && tx_ready)
        chk("no_gap", tx_valid, 1);
      hv = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got data %h sop %b eop %b, required no byte", tx_data, tx_sop, tx_eop);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {tx_data, tx_sop, tx_eop}, {e.d, e.sop, e.eop});
        end
        rx_cnt++;
        if (tx_sop) in_frame = 1'b1;
        if (tx_eop) in_frame = 1'b0;
      end else if (tx_valid) begin
        hv = 1'b1;
        hval = '{tx_data, tx_sop, tx_eop};
      end
    end
  end

  task automatic write_word(input logic [127:0] din, input logic f, input logic l);
    cell_wr = 1'b1;
    cell_din = din;
    cell_first = f;
    cell_last = l;
    tick();
    cell_wr = 1'b0;
  endtask

  task automatic wait_bp_clear();
    int n = 0;
    while (cell_bp && n < 5000) begin
      tick();
      n++;
    end
    if (cell_bp) chk("bp_timeout", 1, 0);
  endtask

  // Reference: payload bytes in order, truncated to min(L, available payload).
  task automatic send_frame(input int L, input int ncells, input bit gaps, input bit honor_bp);
    logic [127:0] pw[$];
    logic [127:0] w, hdr;
    exp_t e;
    int nw, avail, n, idx;
    nw = ncells * 4;
    for (int i = 0; i < nw - 1; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      pw.push_back(w);
    end
    hdr = {$urandom, $urandom, $urandom, $urandom};
    hdr[10:0] = L[10:0];
    avail = (nw - 1) * 16;
    n = (L < avail) ? L : avail;
    if (L > avail) exp_len_err = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = pw[i / 16];
      e.d = w[8 * (15 - (i % 16)) +: 8];
      e.sop = (i == 0);
      e.eop = (i == n - 1);
      exp_q.push_back(e);
    end
    for (int c = 0; c < ncells; c++) begin
      if (honor_bp) wait_bp_clear();
      for (int b = 0; b < 4; b++) begin
        idx = c * 4 + b;
        write_word((idx == 0) ? hdr : pw[idx - 1], c == 0, c == ncells - 1);
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 20000) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (20) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_sop"}, tx_sop, 0);
    chk({tag, "_tx_eop"}, tx_eop, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_cell_bp"}, cell_bp, 0);
    chk({tag, "_ovf_err"}, ovf_err, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  initial begin
    int L, need, cells, base, n;
    repeat (3) tick();
    check_idle_outputs("reset");
    rstn = 1'b1;
    tick();

    ready_mode = 1;
    send_frame(60, 2, 0, 1);
    send_frame(44, 1, 0, 1);
    wait_drain();
    chk("len_err_clean", len_err, 0);
    chk("ovf_err_clean", ovf_err, 0);

    nogap = 1'b1;
    send_frame(100, 2, 0, 1);
    send_frame(16, 1, 0, 1);
    wait_drain();
    nogap = 1'b0;

    ready_mode = 2;
    send_frame(48, 1, 1, 1);
    wait_drain();
    ready_mode = 1;

    // Fill with 16 cells of whole frames while stalled, then overrun with two junk cells.
    ready_mode = 0;
    tick();
    chk("bp_low_before_fill", cell_bp, 0);
    for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 112), 2, 0, 0);
    for (int j = 0; j < 8; j++) write_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    tick();
    tick();
    chk("bp_high_when_full", cell_bp, 1);
    chk("ovf_err_set", ovf_err, 1);
    ready_mode = 1;
    wait_drain();
    send_frame(40, 1, 0, 1);
    wait_drain();
    chk("bp_low_after_drain", cell_bp, 0);
    chk("len_err_after_ovf", len_err, 0);

    send_frame(200, 2, 0, 1);
    send_frame(32, 1, 0, 1);
    wait_drain();
    chk("len_err_short_frame", len_err, exp_len_err);
    chk("ovf_err_sticky", ovf_err, 1);

    ready_mode = 3;
    for (int f = 0; f < 40; f++) begin
      L = $urandom_range(0, 300);
      need = 1 + (L + 15) / 16;
      cells = (need + 3) / 4;
      if (cells > 1 && $urandom_range(0, 5) == 0) cells = $urandom_range(1, cells - 1);
      send_frame(L, cells, 1, 1);
    end
    wait_drain();
    chk("len_err_random", len_err, exp_len_err);

    ready_mode = 1;
    base = rx_cnt;
    send_frame(100, 2, 0, 1);
    n = 0;
    while (rx_cnt < base + 20 && n < 2000) begin
      tick();
      n++;
    end
    chk("reached_byte20", rx_cnt >= base + 20, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    exp_q.delete();
    exp_len_err = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    send_frame(16, 1, 0, 1);
    wait_drain();
    chk("post_reset_len_err", len_err, 0);
    chk("post_reset_ovf_err", ovf_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
